// File: rtl/cs305_clk_pkg.sv
// Shared types and divisor/phase helpers for the cs305 multi-channel clock divider.
package cs305_clk_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_e;

  // Divisors below 2 cannot form a clock, so they collapse to the fastest legal rate.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div < 32'd2) ? 32'd2 : div;
  endfunction

  function automatic logic [31:0] eff_phase(input logic [31:0] phase, input logic [31:0] d);
    return (phase >= d) ? 32'd0 : phase;
  endfunction

  // Starting d-p makes the channel reach zero p cycles after an unshifted channel.
  function automatic logic [31:0] load_val(input logic [31:0] d, input logic [31:0] p);
    return (p == 32'd0) ? 32'd0 : d - p;
  endfunction

endpackage

// File: rtl/cs305_clkdiv_ch.sv
// One divider channel: period counter plus registered divided clock and strobe.
module cs305_clkdiv_ch
  import cs305_clk_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] div,
  input  logic [CNT_W-1:0] phase,
  output logic             outclk,
  output logic             outce
);

  logic [31:0]      d_w;
  logic [31:0]      p_w;
  logic [31:0]      half_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             outclk_q, outclk_d;
  logic             outce_q, outce_d;

  // Outputs are derived from the next count so they line up with the counter value.
  always_comb begin
    d_w    = eff_div(32'(div));
    p_w    = eff_phase(32'(phase), d_w);
    half_w = (d_w + 32'd1) >> 1;
    if (load) begin
      cnt_d = CNT_W'(load_val(d_w, p_w));
    end else if (32'(cnt_q) >= d_w - 32'd1) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    outce_d  = run && (cnt_d == '0);
    outclk_d = run && (32'(cnt_d) < half_w);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      outclk_q <= 1'b0;
      outce_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
      outce_q  <= outce_d;
    end
  end

  assign outclk = outclk_q;
  assign outce  = outce_q;

endmodule

// File: rtl/cs305_clkdiv_gen.sv
// Multi-channel refclk divider: run/settle/lock FSM, per-channel shadow config and
// a valid/ready reprogramming port; any accepted change realigns every channel.
module cs305_clkdiv_gen
  import cs305_clk_pkg::*;
#(
  parameter int                      NUM_CH      = 2,
  parameter int                      CNT_W       = 8,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT    = {8'd5, 8'd2},
  parameter logic [NUM_CH*CNT_W-1:0] PHASE_INIT  = '0,
  parameter int                      LOCK_CYCLES = 16,
  localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outce,
  output logic              locked
);

  localparam int SET_W = $clog2(LOCK_CYCLES + 1);

  state_e                    state_q, state_d;
  logic [SET_W-1:0]          settle_q, settle_d;
  logic [NUM_CH*CNT_W-1:0]   div_q, div_d;
  logic [NUM_CH*CNT_W-1:0]   phase_q, phase_d;
  logic                      xfer;
  logic                      ch_ok;
  logic                      run;
  logic                      load;

  assign cfg_ready = (state_q != SETTLE);
  assign locked    = (state_q == LOCKED);
  assign xfer      = cfg_valid && cfg_ready;
  assign ch_ok     = (int'(cfg_ch) < NUM_CH);

  // Out-of-range channel numbers complete the handshake but touch nothing.
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (xfer && ch_ok && (int'(cfg_ch) == i)) begin
        div_d[i*CNT_W +: CNT_W]   = cfg_div;
        phase_d[i*CNT_W +: CNT_W] = cfg_phase;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    if (!enable) begin
      state_d  = IDLE;
      settle_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = SETTLE;
          settle_d = '0;
        end
        SETTLE: begin
          if (settle_q >= SET_W'(LOCK_CYCLES - 1)) state_d = LOCKED;
          if (settle_q != SET_W'(LOCK_CYCLES)) settle_d = settle_q + 1'b1;
        end
        LOCKED: begin
          if (xfer && ch_ok) begin
            state_d  = SETTLE;
            settle_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counters advance only across consecutive locked cycles; every other edge reloads them,
  // which is what keeps all channels aligned after a relock.
  assign run  = (state_d == LOCKED);
  assign load = !((state_q == LOCKED) && (state_d == LOCKED));

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      div_q    <= DIV_INIT;
      phase_q  <= PHASE_INIT;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cs305_clkdiv_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .refclk (refclk),
      .rst_n  (rst_n),
      .run    (run),
      .load   (load),
      .div    (div_q[g*CNT_W +: CNT_W]),
      .phase  (phase_q[g*CNT_W +: CNT_W]),
      .outclk (outclk[g]),
      .outce  (outce[g])
    );
  end

endmodule

// File: tb/tb_cs305_clkdiv_gen.sv
// Self-checking bench for cs305_clkdiv_gen: time-based reference model checked every
// cycle, directed handshake/enable/reset scenarios with literal expectations, random config traffic.
module tb_cs305_clkdiv_gen;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 1;
  localparam int LOCK   = 16;

  logic              refclk;
  logic              rst_n;
  logic              enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_phase;
  logic [NUM_CH-1:0] outclk;
  logic [NUM_CH-1:0] outce;
  logic              locked;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  cs305_clkdiv_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DIV_INIT    ({8'd5, 8'd2}),
    .PHASE_INIT  ('0),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .outclk    (outclk),
    .outce     (outce),
    .locked    (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Reference model: mode 0 idle, 1 settling, 2 locked; m_t counts cycles since lock.
  int m_mode;
  int m_left;
  int m_t;
  int m_div [NUM_CH];
  int m_ph  [NUM_CH];

  always @(posedge refclk or negedge rst_n) begin : mdl
    int  mode_n, left_n, t_n;
    bit  rdy, acc;
    if (!rst_n) begin
      m_mode   <= 0;
      m_left   <= 0;
      m_t      <= 0;
      m_div[0] <= 2;
      m_div[1] <= 5;
      m_ph[0]  <= 0;
      m_ph[1]  <= 0;
    end else begin
      mode_n = m_mode;
      left_n = m_left;
      t_n    = m_t;
      rdy    = (m_mode != 1);
      acc    = cfg_valid && rdy && (int'(cfg_ch) < NUM_CH);
      if (acc) begin
        m_div[int'(cfg_ch)] <= int'(cfg_div);
        m_ph[int'(cfg_ch)]  <= int'(cfg_phase);
      end
      if (!enable) begin
        mode_n = 0;
      end else if (m_mode == 0) begin
        mode_n = 1;
        left_n = LOCK;
      end else if (m_mode == 1) begin
        left_n = m_left - 1;
        if (left_n == 0) begin
          mode_n = 2;
          t_n    = 0;
        end
      end else if (acc) begin
        mode_n = 1;
        left_n = LOCK;
      end else begin
        t_n = m_t + 1;
      end
      m_mode <= mode_n;
      m_left <= left_n;
      m_t    <= t_n;
    end
  end

  function automatic void mdlOut(output logic [NUM_CH-1:0] c, output logic [NUM_CH-1:0] e);
    int d, p, pos;
    c = '0;
    e = '0;
    if (m_mode == 2) begin
      for (int i = 0; i < NUM_CH; i++) begin
        d   = (m_div[i] < 2) ? 2 : m_div[i];
        p   = (m_ph[i] >= d) ? 0 : m_ph[i];
        pos = (m_t + d - p) % d;
        e[i] = (pos == 0);
        c[i] = (pos < (d + 1) / 2);
      end
    end
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic v, input int ch, input int div, input int ph);
    enable    = en;
    cfg_valid = v;
    cfg_ch    = ch[CH_W-1:0];
    cfg_div   = div[CNT_W-1:0];
    cfg_phase = ph[CNT_W-1:0];
  endtask

  always @(negedge refclk) begin
    logic [NUM_CH-1:0] ec, ee;
    if (rst_n && chk_en) begin
      mdlOut(ec, ee);
      checkOutput("mdl_locked", locked, (m_mode == 2) ? 1 : 0);
      checkOutput("mdl_ready", cfg_ready, (m_mode != 1) ? 1 : 0);
      checkOutput("mdl_outclk", outclk, ec);
      checkOutput("mdl_outce", outce, ee);
    end
  end

  task automatic waitLocked(input int max);
    int n = 0;
    while (!locked && n < max) begin
      @(negedge refclk);
      n++;
    end
    checkOutput("lock_timeout", locked, 1);
  endtask

  // Caller is at a negedge where the very next edge is the first enabled one.
  task automatic lockAndCheckDefaults(input string tag);
    logic [9:0] c0, c1, e0, e1;
    c0 = 10'b0101010101;
    c1 = 10'b0011100111;
    e0 = 10'b0101010101;
    e1 = 10'b0000100001;
    repeat (LOCK) @(negedge refclk);
    checkOutput({tag, "_prelock"}, locked, 0);
    @(negedge refclk);
    for (int k = 0; k < 10; k++) begin
      checkOutput({tag, "_locked"}, locked, 1);
      checkOutput({tag, "_clk0"}, outclk[0], c0[k]);
      checkOutput({tag, "_clk1"}, outclk[1], c1[k]);
      checkOutput({tag, "_ce0"}, outce[0], e0[k]);
      checkOutput({tag, "_ce1"}, outce[1], e1[k]);
      @(negedge refclk);
    end
  endtask

  // Caller is at a negedge while locked; returns at the first relocked cycle.
  task automatic relock(input int ch, input int div, input int ph);
    applyStimulus(1'b1, 1'b1, ch, div, ph);
    @(negedge refclk);
    checkOutput("relock_ready", cfg_ready, 0);
    checkOutput("relock_drop", locked, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    repeat (LOCK - 1) @(negedge refclk);
    checkOutput("relock_settle", locked, 0);
    @(negedge refclk);
    checkOutput("relock_lock", locked, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    repeat (3) @(negedge refclk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge refclk);
    checkOutput("idle_locked", locked, 0);
    checkOutput("idle_ready", cfg_ready, 1);
    checkOutput("idle_outclk", outclk, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    lockAndCheckDefaults("boot");

    relock(1, 4, 1);
    checkOutput("ph1_ce_t0", outce, 2'b01);
    checkOutput("ph1_clk_t0", outclk, 2'b01);
    @(negedge refclk);
    checkOutput("ph1_ce_t1", outce, 2'b10);
    checkOutput("ph1_clk_t1", outclk, 2'b10);

    relock(1, 1, 0);
    checkOutput("div1_ce_t0", outce, 2'b11);
    @(negedge refclk);
    checkOutput("div1_ce_t1", outce, 2'b00);
    checkOutput("div1_clk_t1", outclk, 2'b00);
    relock(0, 0, 0);
    relock(1, 4, 9);
    checkOutput("ph9_ce_t0", outce, 2'b11);
    checkOutput("ph9_clk_t0", outclk, 2'b11);
    @(negedge refclk);
    checkOutput("ph9_clk_t1", outclk, 2'b10);

    applyStimulus(1'b1, 1'b1, 1, 5, 0);
    @(negedge refclk);
    checkOutput("hold_ready", cfg_ready, 0);
    applyStimulus(1'b1, 1'b1, 0, 3, 0);
    repeat (LOCK) @(negedge refclk);
    checkOutput("hold_locked", locked, 1);
    checkOutput("hold_ready_back", cfg_ready, 1);
    checkOutput("hold_ce", outce, 2'b11);
    @(negedge refclk);
    checkOutput("hold_taken", locked, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    waitLocked(40);

    repeat (2) @(negedge refclk);
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    @(negedge refclk);
    checkOutput("dis_outclk", outclk, 0);
    checkOutput("dis_outce", outce, 0);
    checkOutput("dis_locked", locked, 0);
    checkOutput("dis_ready", cfg_ready, 1);
    applyStimulus(1'b0, 1'b1, 0, 4, 2);
    @(negedge refclk);
    checkOutput("idlecfg_locked", locked, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    repeat (LOCK) @(negedge refclk);
    checkOutput("reen_prelock", locked, 0);
    @(negedge refclk);
    checkOutput("reen_locked", locked, 1);
    checkOutput("reen_ce", outce, 2'b10);
    checkOutput("reen_clk", outclk, 2'b10);

    for (int n = 0; n < 800; n++) begin
      @(negedge refclk);
      applyStimulus(($urandom_range(0, 59) != 0), ($urandom_range(0, 29) == 0),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 9)));
    end

    @(negedge refclk);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    waitLocked(60);
    for (int n = 0; n < 12 && outclk == '0; n++) @(negedge refclk);
    checkOutput("pre_rst_active", (outclk != '0) ? 1 : 0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_outclk", outclk, 0);
    checkOutput("arst_outce", outce, 0);
    checkOutput("arst_locked", locked, 0);
    checkOutput("arst_ready", cfg_ready, 1);
    @(negedge refclk);
    rst_n = 1'b1;
    lockAndCheckDefaults("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
